// File: rtl/lcr580_bus_arbiter.sv
// Shared-RAM arbiter between a stepped CPU and a DMA requester.
// The four-state slot machine interleaves CPU steps with bounded DMA bursts.
module lcr580_bus_arbiter #(
    parameter int unsigned BURST = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    output logic [7:0]  cpu_in,
    output logic        cpu_ce,
    input  logic        dma_req,
    input  logic [15:0] dma_address,
    input  logic        dma_we,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    // The top encoding bit marks the DMA-owned slots, so it steers the RAM muxes.
    typedef enum logic [1:0] {
        ST_CA = 2'b00,
        ST_CE = 2'b01,
        ST_DA = 2'b10,
        ST_DD = 2'b11
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] burst_cnt_q;
    logic [3:0] burst_inc;
    logic       cpu_ce_q;
    logic       dma_ack_q;
    logic [7:0] cpu_in_q;
    logic [7:0] dma_rdata_q;
    logic       dma_side;

    assign burst_inc = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
    assign dma_side  = state_q[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CA: begin
                if (run) begin
                    state_d = ST_CE;
                end else if (dma_req) begin
                    state_d = ST_DA;
                end else begin
                    state_d = ST_CA;
                end
            end
            ST_CE: state_d = dma_req ? ST_DA : ST_CA;
            ST_DA: state_d = ST_DD;
            ST_DD: begin
                // A stalled CPU cannot be starved, so the burst limit only applies while running.
                if (dma_req && ((burst_inc < BURST_LIM) || !run)) begin
                    state_d = ST_DA;
                end else begin
                    state_d = ST_CA;
                end
            end
            default: state_d = ST_CA;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CA;
            burst_cnt_q <= 4'd0;
            cpu_ce_q    <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_in_q    <= 8'h00;
            dma_rdata_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cpu_ce_q  <= (state_d == ST_CE);
            dma_ack_q <= (state_d == ST_DD);
            if (state_q == ST_CE) begin
                burst_cnt_q <= 4'd0;
                cpu_in_q    <= mem_rdata;
            end
            if (state_q == ST_DD) begin
                burst_cnt_q <= burst_inc;
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data passes straight through during its own slot and is held afterwards.
    assign cpu_ce      = cpu_ce_q;
    assign dma_ack     = dma_ack_q;
    assign cpu_in      = cpu_ce_q ? mem_rdata : cpu_in_q;
    assign dma_rdata   = dma_ack_q ? mem_rdata : dma_rdata_q;
    assign mem_address = dma_side ? dma_address : cpu_address;
    assign mem_wdata   = dma_side ? dma_wdata : cpu_out;
    assign mem_we      = ((state_q == ST_CA) && cpu_we && run) ||
                         ((state_q == ST_DA) && dma_we);

endmodule
